convclk_ffwrarb: RTL and testbench
==================================

Name: convclk_ffwrarb

Overview:
- Single-clock write-side arbiter and sequencer for the shared dual-clock gray-pointer FIFO control.
- Shares the FIFO write port between NCH packet sources using packet-atomic round-robin arbitration.
- Tags each word with its channel ID and end-of-packet flag.
- Sequences FIFO flushes: flush is requested, waits for packet boundary, pulses the FIFO flush, waits for the write-side flush echo, then resumes.
- Sits in the FIFO write clock domain, directly in front of the FIFO write control.

Parameters:
NCH, 4, number of requesting channels (2..8)
IDW, 2, channel ID width, equals ceil(log2(NCH))
DW, 32, payload width per channel
MAXLEN, 64, maximum words per packet before forced termination (2..255)
FLPW, 2, width of the fifoflush pulse in cycles (1..7)
FLTO, 255, cycles to wait for oflushwr echo before abandoning the flush (8..255)

Ports:
clk  in  1  write-domain clock, same as the FIFO write clock
rst_  in  1  asynchronous active-low reset
req  in  NCH  per-channel word valid
eop  in  NCH  per-channel end-of-packet, qualified by req
din  in  NCH*DW  per-channel payload, channel k at [k*DW+DW-1:k*DW]
ack  out  NCH  word accepted this cycle (combinational)
flushreq  in  1  single-cycle flush request
flushbusy  out  1  flush pending or in progress
fifofull  in  1  FIFO full, write domain
oflushwr  in  1  flush echo from FIFO write domain
fifowr  out  1  FIFO write strobe (combinational)
wrdata  out  DW+IDW+1  {eop, channel ID, payload} (combinational)
fifoflush  out  1  FIFO flush request (registered)
curch  out  IDW  currently granted channel (registered)
lenerr  out  1  sticky: a packet was force-terminated at MAXLEN
flto_err  out  1  sticky: flush echo timeout

Behaviour:
- Reset (rst_ low, asynchronous): state=IDLE, rr pointer=0, curch=0, word counter=0, flush pending=0, fifoflush=0, lenerr=0, flto_err=0.
  - Combinational outputs are all 0 in IDLE.
- FSM states: IDLE, PKT, FLPULSE, FLWAIT.
- IDLE:
  - If flush pending: go to FLPULSE. No grant is issued.
  - Else if any req bit set: grant the first requesting channel at or after the rr pointer (wrapping NCH-1 to 0), load curch, clear the counter, go to PKT.
  - No word is accepted in the arbitration cycle, so there is one bubble per packet.
- PKT:
  - ack[curch] = fifowr = req[curch] & ~fifofull. All other ack bits are 0.
  - wrdata = {eop[curch] | forced, curch, din[curch]}.
  - Each accepted word increments the counter.
  - An accepted word with eop, or the MAXLEN-th accepted word (forced), ends the packet:
    - rr pointer = curch+1, modulo NCH (wraps from NCH-1 to 0).
    - Go to IDLE.
    - If the end was forced, set lenerr; the emitted word carries eop=1.
  - If fifofull is high or req[curch] is low, the block holds the grant with no timeout.
- flushreq:
  - Sets flush pending in any state.
  - New grants are blocked while pending.
  - A packet in progress completes normally before the flush is taken.
  - flushbusy = pending | (state is FLPULSE or FLWAIT).
- FLPULSE:
  - fifoflush=1 for exactly FLPW cycles, counted by the word counter.
  - Clear pending on entry.
  - Then go to FLWAIT with fifoflush=0.
- FLWAIT:
  - Wait until oflushwr has been seen high and then low again.
  - On completion go to IDLE; the rr pointer is unchanged.
  - If FLTO cycles elapse without completion: set flto_err and go to IDLE.
- flushreq arriving during FLPULSE or FLWAIT sets pending again, giving one further flush after the current one (requests do not accumulate beyond one).
- Simultaneous flushreq and grant in IDLE: the flush wins.
- Simultaneous eop and forced termination: counts as a normal eop; lenerr is not set.
- fifofull toggling mid-packet only stalls acceptance; data order is preserved.

Optional Feature:
CONVCLK_WRARB_PRIO_EN:
- Defined: channel 0 has strict priority at every IDLE arbitration. If req[0] is set, channel 0 is granted regardless of the rr pointer, and the rr pointer is not updated after a channel-0 packet. Other channels arbitrate round-robin among themselves.
- Undefined: pure round-robin over all NCH channels.

Test Plan:
- All 4 channels request continuously; each sends 3-word packets (eop on the 3rd) -> grant order 0,1,2,3,0; wrdata ID field matches; 1 bubble between packets; 12 fifowr in 16 cycles.
- Channel 2 holds eop=0 for 70 words with MAXLEN=64 -> 64th word emitted with eop=1; lenerr=1; grant moves to channel 3.
- fifofull high for 5 cycles mid-packet on channel 1 -> ack and fifowr are 0 during those cycles; remaining words are written in order after fifofull falls.
- flushreq on the 2nd word of a 4-word packet -> packet completes; fifoflush high for FLPW=2 cycles; oflushwr pulses 1 then 0; flushbusy deasserts; arbitration resumes at the next channel.
- flushreq with oflushwr held 0 -> flto_err=1 after 255 FLWAIT cycles; return to IDLE.
- With CONVCLK_WRARB_PRIO_EN, channels 0 and 3 requesting continuously -> channel 0 granted every arbitration; channel 3 never granted.
- rst_ low mid-packet -> all outputs 0 immediately; fifowr=0; state IDLE after release.

Source files
------------

// File: rtl/convclk_ffwrarb.sv
// Write-side arbiter/sequencer for the dual-clock gray-pointer FIFO: packet-atomic
// round-robin over NCH sources plus flush sequencing. Option: CONVCLK_WRARB_PRIO_EN.
module convclk_ffwrarb #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned IDW    = 2,
    parameter int unsigned DW     = 32,
    parameter int unsigned MAXLEN = 64,
    parameter int unsigned FLPW   = 2,
    parameter int unsigned FLTO   = 255
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic [NCH-1:0]        req,
    input  logic [NCH-1:0]        eop,
    input  logic [NCH*DW-1:0]     din,
    output logic [NCH-1:0]        ack,
    input  logic                  flushreq,
    output logic                  flushbusy,
    input  logic                  fifofull,
    input  logic                  oflushwr,
    output logic                  fifowr,
    output logic [DW+IDW:0]       wrdata,
    output logic                  fifoflush,
    output logic [IDW-1:0]        curch,
    output logic                  lenerr,
    output logic                  flto_err
);

    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {IDLE, PKT, FLPULSE, FLWAIT} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  curch_q, curch_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            flush_q, flush_d;
    logic            lenerr_q, lenerr_d;
    logic            flto_q, flto_d;
    logic            seen_q, seen_d;

    logic            sel_req, sel_eop, forced, found;
    logic [DW-1:0]   sel_din;
    logic [IDW-1:0]  gnt, rr_next;
    int unsigned     idx;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            curch_q  <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
            flush_q  <= 1'b0;
            lenerr_q <= 1'b0;
            flto_q   <= 1'b0;
            seen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            curch_q  <= curch_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            flush_q  <= flush_d;
            lenerr_q <= lenerr_d;
            flto_q   <= flto_d;
            seen_q   <= seen_d;
        end
    end

    // Mux of the granted channel's inputs.
    always_comb begin
        sel_req = 1'b0;
        sel_eop = 1'b0;
        sel_din = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (IDW'(k) == curch_q) begin
                sel_req = req[k];
                sel_eop = eop[k];
                sel_din = din[k*DW +: DW];
            end
        end
    end

    // First requester at or after the rr pointer, wrapping.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt   = IDW'(idx);
            end
        end
`ifdef CONVCLK_WRARB_PRIO_EN
        if (req[0]) gnt = '0;
`endif
    end

    always_comb begin
        rr_next = (curch_q == IDW'(NCH-1)) ? '0 : curch_q + 1'b1;
`ifdef CONVCLK_WRARB_PRIO_EN
        if (curch_q == '0) rr_next = rr_q;
`endif
    end

    assign forced = (cnt_q == CW'(MAXLEN-1));

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        curch_d  = curch_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q | flushreq;
        flush_d  = flush_q;
        lenerr_d = lenerr_q;
        flto_d   = flto_q;
        seen_d   = seen_q;
        ack      = '0;
        fifowr   = 1'b0;
        wrdata   = '0;
        case (state_q)
            IDLE: begin
                // A flush request in the same cycle as a possible grant takes priority.
                if (pend_q || flushreq) begin
                    state_d = FLPULSE;
                    pend_d  = 1'b0;
                    flush_d = 1'b1;
                    cnt_d   = '0;
                    seen_d  = 1'b0;
                end else if (|req) begin
                    state_d = PKT;
                    curch_d = gnt;
                    cnt_d   = '0;
                end
            end
            PKT: begin
                fifowr = sel_req & ~fifofull;
                wrdata = {sel_eop | forced, curch_q, sel_din};
                for (int unsigned k = 0; k < NCH; k++)
                    ack[k] = fifowr && (IDW'(k) == curch_q);
                if (fifowr) begin
                    cnt_d = cnt_q + 1'b1;
                    if (sel_eop || forced) begin
                        state_d = IDLE;
                        rr_d    = rr_next;
                        if (!sel_eop) lenerr_d = 1'b1;
                    end
                end
            end
            FLPULSE: begin
                seen_d = seen_q | oflushwr;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(FLPW-1)) begin
                    flush_d = 1'b0;
                    cnt_d   = '0;
                    state_d = FLWAIT;
                end
            end
            FLWAIT: begin
                seen_d = seen_q | oflushwr;
                cnt_d  = cnt_q + 1'b1;
                if (seen_q && !oflushwr) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(FLTO-1)) begin
                    flto_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign flushbusy = pend_q | (state_q == FLPULSE) | (state_q == FLWAIT);
    assign fifoflush = flush_q;
    assign curch     = curch_q;
    assign lenerr    = lenerr_q;
    assign flto_err  = flto_q;

endmodule

// File: tb/tb_convclk_ffwrarb.sv
// Directed bench for convclk_ffwrarb: arbitration order, forced termination, stall,
// flush sequencing, flush timeout and asynchronous reset.
module tb_convclk_ffwrarb;

    localparam int NCH = 4;
    localparam int IDW = 2;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              rst_ = 1'b0;
    logic [NCH-1:0]    req = '0;
    logic [NCH-1:0]    eop = '0;
    logic [NCH*DW-1:0] din = '0;
    logic [NCH-1:0]    ack;
    logic              flushreq = 1'b0;
    logic              flushbusy;
    logic              fifofull = 1'b0;
    logic              oflushwr = 1'b0;
    logic              fifowr;
    logic [DW+IDW:0]   wrdata;
    logic              fifoflush;
    logic [IDW-1:0]    curch;
    logic              lenerr;
    logic              flto_err;

    int n_assert = 0;
    int n_fail   = 0;
    int wcnt[NCH];
    int pkt_len[NCH];
    int nwr;

    convclk_ffwrarb #(.NCH(NCH), .IDW(IDW), .DW(DW), .MAXLEN(64), .FLPW(2), .FLTO(255)) dut (
        .clk(clk), .rst_(rst_), .req(req), .eop(eop), .din(din), .ack(ack),
        .flushreq(flushreq), .flushbusy(flushbusy), .fifofull(fifofull),
        .oflushwr(oflushwr), .fifowr(fifowr), .wrdata(wrdata), .fifoflush(fifoflush),
        .curch(curch), .lenerr(lenerr), .flto_err(flto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [DW+IDW:0] wd(input logic e, input int ch, input int w);
        return {e, IDW'(ch), 8'(8'hC0 + ch), 24'(w)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_src();
        for (int k = 0; k < NCH; k++) begin
            din[k*DW +: DW] = {8'(8'hC0 + k), 24'(wcnt[k])};
            eop[k] = (pkt_len[k] != 0) && ((wcnt[k] % pkt_len[k]) == pkt_len[k] - 1);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic tick(input logic ff, input logic fr, input logic ofw);
        @(negedge clk);
        fifofull = ff;
        flushreq = fr;
        oflushwr = ofw;
        drive_src();
        #1;
        for (int k = 0; k < NCH; k++) if (ack[k]) wcnt[k]++;
    endtask

    // Leaves the DUT in its first post-reset cycle (c0), already sampled.
    task automatic do_reset();
        rst_ = 1'b0;
        for (int k = 0; k < NCH; k++) wcnt[k] = 0;
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        fifofull = 1'b0;
        flushreq = 1'b0;
        oflushwr = 1'b0;
        drive_src();
        #1;
    endtask

    task automatic set_src(input logic [NCH-1:0] r, input int l0, input int l1, input int l2, input int l3);
        req = r;
        pkt_len[0] = l0; pkt_len[1] = l1; pkt_len[2] = l2; pkt_len[3] = l3;
    endtask

    initial begin
`ifdef CONVCLK_WRARB_PRIO_EN
        // Channel 0 priority: channel 3 never granted.
        set_src(4'b1001, 2, 0, 0, 2);
        do_reset();
        for (int c = 1; c <= 12; c++) begin
            tick(0, 0, 0);
            chk("prio_ack3", ack[3], 0);
            if (c % 3 != 0) chk("prio_curch", curch, 0);
        end
`else
        // Round-robin, 3-word packets on all channels.
        set_src(4'b1111, 3, 3, 3, 3);
        do_reset();
        chk("rr_c0_fifowr", fifowr, 0);
        nwr = 0;
        for (int c = 1; c <= 15; c++) begin
            tick(0, 0, 0);
            chk("rr_fifowr", fifowr, (c % 4 != 0));
            if (fifowr) nwr++;
            if (c % 4 != 0) begin
                chk("rr_wrdata", wrdata, wd((c % 4) == 3, c / 4, (c % 4) - 1));
                chk("rr_curch", curch, c / 4);
            end
        end
        chk("rr_nwr16", nwr, 12);
        tick(0, 0, 0);
        chk("rr_c16_bubble", fifowr, 0);
        tick(0, 0, 0);
        chk("rr_c17_curch", curch, 0);
        chk("rr_c17_wrdata", wrdata, wd(0, 0, 3));
`endif

        // Forced termination at MAXLEN on channel 2, then channel 3.
        set_src(4'b1100, 0, 0, 0, 2);
        do_reset();
        for (int c = 1; c <= 64; c++) begin
            tick(0, 0, 0);
            if (c == 63) chk("len_w62", wrdata, wd(0, 2, 62));
            if (c == 64) begin
                chk("len_w63_eop", wrdata, wd(1, 2, 63));
                chk("len_before", lenerr, 0);
            end
        end
        tick(0, 0, 0);
        chk("len_lenerr", lenerr, 1);
        chk("len_bubble", fifowr, 0);
        tick(0, 0, 0);
        chk("len_next_curch", curch, 3);
        chk("len_next_wrdata", wrdata, wd(0, 3, 0));

        // Asynchronous reset mid-packet.
        set_src(4'b0100, 0, 0, 0, 0);
        do_reset();
        chk("rst_lenerr_clr", lenerr, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("rst_pre_curch", curch, 2);
        rst_ = 1'b0;
        #1;
        chk("rst_fifowr", fifowr, 0);
        chk("rst_ack", ack, 0);
        chk("rst_wrdata", wrdata, 0);
        chk("rst_curch", curch, 0);
        chk("rst_fifoflush", fifoflush, 0);
        chk("rst_flushbusy", flushbusy, 0);
        do_reset();
        chk("rst_idle_fifowr", fifowr, 0);
        tick(0, 0, 0);
        chk("rst_regrant", wrdata, wd(0, 2, 0));

        // eop coinciding with the MAXLEN-th word is a normal end.
        set_src(4'b0100, 0, 0, 64, 0);
        do_reset();
        for (int c = 1; c <= 64; c++) tick(0, 0, 0);
        chk("eopmax_wrdata", wrdata, wd(1, 2, 63));
        tick(0, 0, 0);
        chk("eopmax_lenerr", lenerr, 0);

        // fifofull stall on channel 1.
        set_src(4'b0010, 0, 6, 0, 0);
        do_reset();
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("stall_w1", wrdata, wd(0, 1, 1));
        for (int c = 3; c <= 7; c++) begin
            tick(1, 0, 0);
            chk("stall_ack", ack, 0);
            chk("stall_fifowr", fifowr, 0);
        end
        for (int c = 8; c <= 11; c++) begin
            tick(0, 0, 0);
            chk("stall_resume", wrdata, wd(c == 11, 1, c - 6));
        end
        tick(0, 0, 0);
        chk("stall_end_bubble", fifowr, 0);

        // Flush requested mid-packet on channel 1.
        set_src(4'b0110, 0, 4, 4, 0);
        do_reset();
        tick(0, 0, 0);
        tick(0, 1, 0);
        tick(0, 0, 0);
        chk("fl_busy_pending", flushbusy, 1);
        chk("fl_pkt_continues", wrdata, wd(0, 1, 2));
        tick(0, 0, 0);
        chk("fl_pkt_last", wrdata, wd(1, 1, 3));
        tick(0, 0, 0);
        chk("fl_no_grant", fifowr, 0);
        chk("fl_no_ack", ack, 0);
        tick(0, 0, 0);
        chk("fl_pulse1", fifoflush, 1);
        tick(0, 0, 0);
        chk("fl_pulse2", fifoflush, 1);
        tick(0, 0, 1);
        chk("fl_pulse_end", fifoflush, 0);
        chk("fl_wait_busy", flushbusy, 1);
        tick(0, 0, 0);
        chk("fl_wait_busy2", flushbusy, 1);
        tick(0, 0, 0);
        chk("fl_done_busy", flushbusy, 0);
        chk("fl_done_idle", fifowr, 0);
        tick(0, 0, 0);
        chk("fl_resume_curch", curch, 2);
        chk("fl_resume_wrdata", wrdata, wd(0, 2, 0));

        // Flush echo never arrives: timeout.
        set_src(4'b0000, 0, 0, 0, 0);
        do_reset();
        tick(0, 1, 0);
        for (int c = 2; c <= 258; c++) begin
            tick(0, 0, 0);
            if (c == 2) chk("to_pulse", fifoflush, 1);
            if (c == 4) chk("to_pulse_end", fifoflush, 0);
        end
        chk("to_before_err", flto_err, 0);
        chk("to_before_busy", flushbusy, 1);
        tick(0, 0, 0);
        chk("to_flto_err", flto_err, 1);
        chk("to_idle_busy", flushbusy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
